// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D_intf conversion scheduler.
package a2d_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CONV  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Sweep order matches the channel sequence A2D_intf steps through on each nxt.
    typedef enum logic [1:0] {
        CH_LFT   = 2'd0,
        CH_RGHT  = 2'd1,
        CH_STEER = 2'd2,
        CH_BATT  = 2'd3
    } chan_t;

endpackage

// File: rtl/a2d_sched.sv
// Conversion scheduler: paces nxt requests to A2D_intf, tracks the channel in
// flight, strobes per-channel updates and flags conversions that never finish.
module a2d_sched
    import a2d_pkg::*;
#(
    parameter int unsigned PERIOD  = 4096,
    parameter int unsigned TMO_CYC = 3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cnv_done,
    input  logic              clr_err,
    output logic              nxt,
    output logic [1:0]        chan,
    output logic [NUM_CH-1:0] vld,
    output logic [NUM_CH-1:0] fresh,
    output logic              tmo_err
);

    localparam int unsigned   CW      = $clog2(PERIOD);
    localparam logic [CW-1:0] P_TC    = CW'(PERIOD - 1);
    localparam logic [CW-1:0] T_TC    = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    chan_t             chan_q, chan_d;
    logic              nxt_q, nxt_d;
    logic [NUM_CH-1:0] vld_q, vld_d;
    logic [NUM_CH-1:0] fresh_q, fresh_d;
    logic              tmo_q, tmo_d;
    logic [CW-1:0]     pcnt_q, pcnt_d;
    logic [CW-1:0]     tcnt_q, tcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= CH_LFT;
            nxt_q   <= 1'b0;
            vld_q   <= '0;
            fresh_q <= '0;
            tmo_q   <= 1'b0;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            nxt_q   <= nxt_d;
            vld_q   <= vld_d;
            fresh_q <= fresh_d;
            tmo_q   <= tmo_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        vld_d   = '0;
        fresh_d = fresh_q;
        tmo_d   = tmo_q;
        pcnt_d  = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
        tcnt_d  = tcnt_q;

        if (clr_err)
            tmo_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (en)
                    state_d = ISSUE;
            end
            ISSUE: begin
                tcnt_d  = tcnt_q + 1'b1;
                state_d = CONV;
            end
            CONV: begin
                tcnt_d = (tcnt_q == CNT_MAX) ? tcnt_q : tcnt_q + 1'b1;
                if (cnv_done) begin
                    vld_d[chan_q]   = 1'b1;
                    fresh_d[chan_q] = 1'b1;
                    chan_d          = chan_t'(chan_q + 2'd1);
                    state_d         = GAP;
                end else if (tcnt_q == T_TC) begin
                    // A2D_intf steps its own channel on every nxt, so advance anyway.
                    tmo_d           = 1'b1;
                    fresh_d[chan_q] = 1'b0;
                    chan_d          = chan_t'(chan_q + 2'd1);
                    state_d         = GAP;
                end
            end
            GAP: begin
                if (pcnt_q == P_TC)
                    state_d = en ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counters read 0 during the nxt cycle so terminal counts land exactly
        // PERIOD / TMO_CYC cycles after the request.
        if (state_d == ISSUE || state_d == IDLE) begin
            pcnt_d = '0;
            tcnt_d = '0;
        end

        nxt_d = (state_d == ISSUE);
    end

    assign nxt     = nxt_q;
    assign chan    = chan_q;
    assign vld     = vld_q;
    assign fresh   = fresh_q;
    assign tmo_err = tmo_q;

endmodule

// File: tb/tb_a2d_sched.sv
// Scoreboard bench for a2d_sched with a behavioral cnv_done driver.
module tb_a2d_sched;
    localparam int unsigned PERIOD  = 64;
    localparam int unsigned TMO_CYC = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cnv_done = 1'b0;
    logic       clr_err = 1'b0;
    logic       nxt;
    logic [1:0] chan;
    logic [3:0] vld;
    logic [3:0] fresh;
    logic       tmo_err;

    a2d_sched #(.PERIOD(PERIOD), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cnv_done(cnv_done), .clr_err(clr_err),
        .nxt(nxt), .chan(chan), .vld(vld), .fresh(fresh), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] vld;
        logic [1:0] chan;
        logic [3:0] fresh;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_chan  = 2'd0;
    logic [3:0] m_fresh = 4'd0;

    function automatic void exp_done();
        logic [3:0] b;
        b       = 4'b0001 << m_chan;
        m_chan  = m_chan + 2'd1;
        m_fresh = m_fresh | b;
        sb.push_back('{vld: b, chan: m_chan, fresh: m_fresh});
    endfunction

    function automatic void exp_timeout();
        logic [3:0] b;
        b       = 4'b0001 << m_chan;
        m_chan  = m_chan + 2'd1;
        m_fresh = m_fresh & ~b;
    endfunction

    logic nxt_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && vld !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("vld_unexpected", 32'(vld), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("vld", 32'(vld), 32'(e.vld));
                chk("vld_chan", 32'(chan), 32'(e.chan));
                chk("vld_fresh", 32'(fresh), 32'(e.fresh));
            end
        end
        if (nxt_prev && nxt)
            chk("nxt_width", 32'(nxt), 32'h0);
        nxt_prev = nxt;
    end

    task automatic wait_nxt(output int t);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (nxt === 1'b1) begin
                t = cyc;
                return;
            end
        end
        chk("nxt_timeout", 32'h0, 32'h1);
        t = cyc;
    endtask

    // Called at the negedge of the nxt cycle; done is high n cycles later.
    task automatic do_done(input int n);
        exp_done();
        repeat (n) @(posedge clk);
        #1 cnv_done = 1'b1;
        @(posedge clk);
        #1 cnv_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        chk("chan_after", 32'(chan), 32'(m_chan));
    endtask

    int t, prev, rel, cnt;

    initial begin
        // 1: reset values, start latency, first done
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nxt", 32'(nxt), 32'h0);
        chk("rst_chan", 32'(chan), 32'h0);
        chk("rst_vld", 32'(vld), 32'h0);
        chk("rst_fresh", 32'(fresh), 32'h0);
        chk("rst_tmo", 32'(tmo_err), 32'h0);
        rst_n = 1'b1;
        rel = cyc;
        wait_nxt(t);
        chk("start_lat", 32'(t - rel), 32'h1);
        prev = t;
        do_done(20);
        chk("t1_chan", 32'(chan), 32'h1);
        chk("t1_fresh", 32'(fresh), 32'h1);

        // 2: rest of the sweep, cadence
        for (int k = 1; k < 4; k++) begin
            wait_nxt(t);
            chk("cadence", 32'(t - prev), PERIOD);
            prev = t;
            do_done(20);
        end
        chk("sweep_fresh", 32'(fresh), 32'hF);
        chk("sweep_chan", 32'(chan), 32'h0);

        // 3: timeout on channel 2
        for (int k = 0; k < 2; k++) begin
            wait_nxt(t);
            chk("cadence", 32'(t - prev), PERIOD);
            prev = t;
            do_done(20);
        end
        wait_nxt(t);
        chk("cadence", 32'(t - prev), PERIOD);
        prev = t;
        repeat (TMO_CYC - 1) @(negedge clk);
        chk("tmo_early", 32'(tmo_err), 32'h0);
        @(negedge clk);
        chk("tmo_set", 32'(tmo_err), 32'h1);
        exp_timeout();
        chk("tmo_fresh", 32'(fresh), 32'hB);
        chk("tmo_chan", 32'(chan), 32'h3);
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err", 32'(tmo_err), 32'h0);
        wait_nxt(t);
        chk("cadence_after_tmo", 32'(t - prev), PERIOD);
        prev = t;

        // 4: done coincident with timeout terminal count, then clr vs set
        do_done(TMO_CYC - 1);
        chk("done_wins_tmo", 32'(tmo_err), 32'h0);
        wait_nxt(t);
        chk("cadence", 32'(t - prev), PERIOD);
        prev = t;
        repeat (TMO_CYC - 1) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
        chk("set_wins_clr", 32'(tmo_err), 32'h1);
        exp_timeout();
        repeat (3) @(negedge clk);
        chk("tmo_sticky", 32'(tmo_err), 32'h1);
        chk("tmo2_fresh", 32'(fresh), 32'(m_fresh));

        // 5: en drops mid-conversion
        wait_nxt(t);
        chk("cadence", 32'(t - prev), PERIOD);
        exp_done();
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        repeat (15) @(posedge clk);
        #1 cnv_done = 1'b1;
        @(posedge clk);
        #1 cnv_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (nxt) cnt++;
        end
        chk("no_nxt_after_en_drop", 32'(cnt), 32'h0);
        chk("sb_drain_en_drop", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1 cnv_done = 1'b1;
        @(posedge clk);
        #1 cnv_done = 1'b0;
        @(negedge clk);
        chk("idle_done_vld", 32'(vld), 32'h0);
        chk("idle_done_chan", 32'(chan), 32'(m_chan));
        @(posedge clk);
        #1 en = 1'b1;
        rel = cyc;
        wait_nxt(t);
        chk("idle_restart_lat", 32'(t - rel), 32'h1);
        chk("idle_restart_chan", 32'(chan), 32'h2);
        prev = t;

        // 6: reset mid-conversion on channel 1
        do_done(20);
        for (int k = 0; k < 2; k++) begin
            wait_nxt(t);
            chk("cadence", 32'(t - prev), PERIOD);
            prev = t;
            do_done(20);
        end
        wait_nxt(t);
        chk("pre_rst_chan", 32'(chan), 32'h1);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("arst_nxt", 32'(nxt), 32'h0);
        chk("arst_chan", 32'(chan), 32'h0);
        chk("arst_vld", 32'(vld), 32'h0);
        chk("arst_fresh", 32'(fresh), 32'h0);
        chk("arst_tmo", 32'(tmo_err), 32'h0);
        m_chan  = 2'd0;
        m_fresh = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        wait_nxt(t);
        chk("rst_restart_lat", 32'(t - rel), 32'h1);
        chk("rst_restart_chan", 32'(chan), 32'h0);
        do_done(20);
        chk("final_fresh", 32'(fresh), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/a2d_sched.md
# a2d_sched

Conversion scheduler for the A2D_intf SPI front end. It issues the one-cycle `nxt` request at a programmed cadence and tracks which channel of the round-robin sweep (lft_ld, rght_ld, steer_pot, batt) is in flight. It emits a per-channel update strobe on each completed conversion and flags conversions that never complete. It sits between the balance/steering control logic and A2D_intf, so no consumer has to generate `nxt` or infer channel order itself.

## Interface
- `PERIOD`, default 4096: minimum cycles from one `nxt` pulse to the next. Legal values are ≥ 4.
- `TMO_CYC`, default 3000: cycles allowed from `nxt` to `cnv_done` before a timeout is declared. Must be < `PERIOD`.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  level input; enables continuous sweeping.
- `cnv_done`  in  1  one-cycle pulse from A2D_intf when a result register is loaded.
- `clr_err`  in  1  one-cycle pulse; clears `tmo_err`.
- `nxt`  out  1  conversion request to A2D_intf. Registered; high exactly one cycle per request.
- `chan`  out  2  channel of the current or last request: 0 = lft_ld, 1 = rght_ld, 2 = steer_pot, 3 = batt.
- `vld`  out  4  one-hot, one-cycle update strobe; bit = channel just completed.
- `fresh`  out  4  per-channel "holds a valid result since reset" mask.
- `tmo_err`  out  1  sticky timeout flag.

## Operation
- **States:** IDLE, ISSUE, CONV, GAP. Encoding lives in the package.
- **IDLE**
  - `en`=1 → ISSUE.
  - `cnv_done` is ignored in IDLE.
- **ISSUE** (one cycle)
  - `nxt`=1.
  - Period counter and timeout counter both load 0.
  - Always → CONV.
- **CONV**
  - Both counters increment each cycle.
  - On `cnv_done`:
    - `vld[chan]` pulses and `fresh[chan]` sets.
    - `chan` ← `chan`+1 mod 4.
    - → GAP.
  - Timeout: if the timeout counter reaches `TMO_CYC`-1 without `cnv_done`:
    - `tmo_err` sets and `fresh[chan]` clears.
    - `chan` still advances, because A2D_intf advances its own channel on every `nxt`.
    - → GAP.
- **GAP**
  - The period counter keeps running.
  - When it reaches `PERIOD`-1: `en`=1 → ISSUE; `en`=0 → IDLE.
- **`en` dropping mid-CONV:** the conversion finishes normally (done or timeout) and the FSM exits through GAP. It never abandons an issued request.
- **`cnv_done` outside CONV:** ignored. No strobe, no `chan` change.
- **Simultaneous `cnv_done` and timeout terminal count:** done wins. Strobe fires, no error.
- **Simultaneous `clr_err` and a new timeout:** set wins; `tmo_err` stays 1.
- **Counter widths:** `$clog2(PERIOD)` bits. Counters saturate; they never wrap.

## Timing
- **Reset values:** state IDLE, `nxt`=0, `chan`=0, `vld`=0, `fresh`=0, `tmo_err`=0, counters 0.
- **Start latency:** `en` sampled high in IDLE at edge k → `nxt` high during cycle k+1.
- **Cadence:** consecutive `nxt` pulses are exactly `PERIOD` cycles apart while `en` stays high.
- **Strobe latency:** `vld` and `fresh` update on the edge after the `cnv_done` cycle. `chan` updates on the same edge.
- **Error latency:** `tmo_err` rises `TMO_CYC` cycles after the `nxt` cycle.
- **Reset mid-operation:** everything returns to reset values immediately. A2D_intf shares `rst_n`, so both channel counters realign to 0.

## Structure
- **Package `a2d_pkg`:**
  - `state_t` enum (IDLE/ISSUE/CONV/GAP).
  - `chan_t` enum (CH_LFT=0, CH_RGHT=1, CH_STEER=2, CH_BATT=3).
  - `NUM_CH`=4.
- **Module layout:** single module, no sub-module. The two counters are inline.

## Test plan
Bench uses `PERIOD`=64, `TMO_CYC`=40 and a behavioral `cnv_done` driver.
1. Reset with `en`=1, release → first `nxt` 1 cycle after release. Drive done 20 cycles later → `vld`=4'b0001, `chan`=1, `fresh`=4'b0001.
2. Full sweep of 4 conversions, done 20 cycles after each `nxt` → `nxt` spacing exactly 64. `vld` strobes 0001, 0010, 0100, 1000. `fresh`=4'hF. `chan` wraps to 0.
3. No done after an `nxt` on channel 2 → `tmo_err`=1 exactly 40 cycles after `nxt`. `fresh[2]`=0, `chan`=3, next `nxt` still at 64.
4. `cnv_done` on the same cycle as the timeout terminal count → `vld` pulse, `tmo_err` stays 0. Separately, pulse `clr_err` alongside a new timeout → `tmo_err` stays 1.
5. Drop `en` 5 cycles after `nxt`, done at cycle 20 → strobe still fires, no further `nxt`, IDLE reached at cycle 64. Spurious done in IDLE → no `vld`.
6. Assert `rst_n` low in mid-CONV on channel 1 → all outputs 0 asynchronously. Restart yields `chan`=0 on the first `nxt`.
